// File: rtl/md_cart_bridge_if.sv
// Cartridge bus and ROM request port seen by the cart bridge.
// The bridge takes the slave side; the board and ROM model take the master side.
interface md_cart_bridge_if;
  logic [22:0] cart_address;
  logic        cart_cs;
  logic        cart_oe;
  logic        cart_lwr;
  logic        cart_uwr;
  logic        cart_time;
  logic [15:0] cart_data_wr;
  logic [15:0] cart_data;
  logic        cart_data_en;
  logic        ext_dtack;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        timeout_err;

  modport slave (
    input  cart_address, cart_cs, cart_oe, cart_lwr, cart_uwr, cart_time, cart_data_wr,
    input  mem_ack, mem_rdata,
    output cart_data, cart_data_en, ext_dtack, mem_req, mem_addr, timeout_err
  );

  modport master (
    output cart_address, cart_cs, cart_oe, cart_lwr, cart_uwr, cart_time, cart_data_wr,
    output mem_ack, mem_rdata,
    input  cart_data, cart_data_en, ext_dtack, mem_req, mem_addr, timeout_err
  );
endinterface

// File: rtl/md_cart_bridge.sv
// Cartridge responder: ROM word fetches through an SSF2-style bank mapper,
// battery SRAM, and the $A130xx control registers that steer both.
module md_cart_bridge #(
  parameter int SRAM_AW     = 13,
  parameter bit MAPPER_EN   = 1'b1,
  parameter int ROM_TIMEOUT = 48
) (
  input logic           MCLK2,
  input logic           SRES,
  md_cart_bridge_if.slave bus
);
  localparam int TW = (ROM_TIMEOUT > 1) ? $clog2(ROM_TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, SRAM_RD, FETCH, ABANDON, HOLD} state_t;

  state_t               state;
  logic                 active_q;
  logic                 wr_q;
  logic                 strobe;
  logic                 wr_lvl;
  logic                 read_go;
  logic                 wr_go;
  logic [5:0]           bank [0:7];
  logic                 sram_en;
  logic                 sram_wp;
  logic                 sram_hit;
  logic                 sram_we;
  logic [TW-1:0]        tmo_cnt;
  logic [23:0]          mapped;
  logic [SRAM_AW-1:0]   sram_idx;
  logic [7:0]           sram [0:(1<<SRAM_AW)-1];
  logic [7:0]           sram_q;
  logic                 unused_bits;

  assign unused_bits = ^{bus.cart_address[22:21], bus.cart_data_wr[15:8]};
  assign bus.ext_dtack = 1'b0;

  always_comb begin
    strobe   = bus.cart_cs & bus.cart_oe;
    wr_lvl   = (bus.cart_lwr | bus.cart_uwr) & (bus.cart_cs | bus.cart_time);
    read_go  = strobe & ~bus.cart_time & ~active_q;
    wr_go    = wr_lvl & ~wr_q;
    sram_hit = sram_en & bus.cart_address[20];
    sram_idx = bus.cart_address[SRAM_AW-1:0];
    sram_we  = wr_go & bus.cart_cs & bus.cart_lwr & sram_hit & ~sram_wp;
    mapped   = {3'b000, bus.cart_address[20:0]};
    if (MAPPER_EN)
      mapped = {bank[bus.cart_address[20:18]], bus.cart_address[17:0]};
  end

  // Battery RAM keeps its contents across reset, so it has no reset branch.
  always_ff @(posedge MCLK2) begin
    if (sram_we)
      sram[sram_idx] <= bus.cart_data_wr[7:0];
    sram_q <= sram[sram_idx];
  end

  always_ff @(posedge MCLK2) begin
    if (!SRES) begin
      state            <= IDLE;
      active_q         <= 1'b0;
      wr_q             <= 1'b0;
      sram_en          <= 1'b0;
      sram_wp          <= 1'b0;
      tmo_cnt          <= '0;
      bus.cart_data    <= 16'h0000;
      bus.cart_data_en <= 1'b0;
      bus.mem_req      <= 1'b0;
      bus.mem_addr     <= 24'h000000;
      bus.timeout_err  <= 1'b0;
      for (int i = 0; i < 8; i++)
        bank[i] <= 6'(i);
    end else begin
      active_q <= strobe;
      wr_q     <= wr_lvl;

      // Register writes land with non-blocking timing, so a read starting
      // on the same edge still maps through the old bank value.
      if (wr_go && bus.cart_time && bus.cart_lwr) begin
        if (bus.cart_address[6:0] == 7'h78) begin
          sram_en <= bus.cart_data_wr[0];
          sram_wp <= bus.cart_data_wr[1];
        end else if (MAPPER_EN && bus.cart_address[6:0] >= 7'h79) begin
          bank[bus.cart_address[2:0]] <= bus.cart_data_wr[5:0];
        end
      end

      case (state)
        IDLE: begin
          if (read_go) begin
            if (sram_hit) begin
              state <= SRAM_RD;
            end else begin
              state        <= FETCH;
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= mapped;
              tmo_cnt      <= TW'(ROM_TIMEOUT - 1);
            end
          end
        end
        SRAM_RD: begin
          bus.cart_data    <= {8'hFF, sram_q};
          bus.cart_data_en <= 1'b1;
          state            <= HOLD;
        end
        FETCH: begin
          if (bus.mem_ack) begin
            bus.mem_req      <= 1'b0;
            bus.cart_data    <= bus.mem_rdata;
            bus.cart_data_en <= 1'b1;
            state            <= HOLD;
          end else if (tmo_cnt == '0) begin
            bus.timeout_err  <= 1'b1;
            bus.cart_data    <= 16'hFFFF;
            bus.cart_data_en <= 1'b1;
            state            <= ABANDON;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        ABANDON: begin
          // The bus already has 16'hFFFF; the late ROM word is discarded.
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (strobe) begin
              state <= HOLD;
            end else begin
              bus.cart_data_en <= 1'b0;
              state            <= IDLE;
            end
          end
        end
        HOLD: begin
          if (!strobe) begin
            bus.cart_data_en <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md_cart_bridge.sv
// Directed and randomized checks of md_cart_bridge against a behavioural
// model of the bank map, control registers and a window of SRAM bytes.
module tb_md_cart_bridge;
  localparam int TO = 48;

  logic MCLK2 = 1'b0;
  logic SRES  = 1'b0;
  md_cart_bridge_if bus ();

  md_cart_bridge #(.SRAM_AW(13), .MAPPER_EN(1'b1), .ROM_TIMEOUT(TO)) dut (
    .MCLK2(MCLK2),
    .SRES (SRES),
    .bus  (bus)
  );

  always #5 MCLK2 = ~MCLK2;

  int checks   = 0;
  int failures = 0;

  logic [5:0] m_bank [8];
  logic       m_sram_en, m_sram_wp, m_tmo;
  logic [7:0] m_sram [16];

  task automatic tick();
    @(posedge MCLK2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_bank[i] = 6'(i);
    m_sram_en = 1'b0;
    m_sram_wp = 1'b0;
    m_tmo     = 1'b0;
  endtask

  function automatic logic [22:0] win(input logic [3:0] i);
    logic [22:0] a;
    a       = 23'($urandom);
    a[20]   = 1'b1;
    a[12:4] = 9'd0;
    a[3:0]  = i;
    return a;
  endfunction

  // One write cycle, either to the TIME region or to cart space.
  task automatic wr(input logic tm, input logic lw, input logic uw,
                    input logic [22:0] a, input logic [15:0] d);
    bus.cart_address = a;
    bus.cart_data_wr = d;
    bus.cart_time    = tm;
    bus.cart_cs      = ~tm;
    bus.cart_lwr     = lw;
    bus.cart_uwr     = uw;
    tick();
    bus.cart_lwr  = 1'b0;
    bus.cart_uwr  = 1'b0;
    tick();
    bus.cart_time = 1'b0;
    bus.cart_cs   = 1'b0;
    tick();
    if (tm && lw && a[6:0] == 7'h78) begin
      m_sram_en = d[0];
      m_sram_wp = d[1];
    end else if (tm && lw && a[6:0] >= 7'h79) begin
      m_bank[a[2:0]] = d[5:0];
    end
    if (!tm && lw && m_sram_en && a[20] && !m_sram_wp && a[12:4] == 9'd0)
      m_sram[a[3:0]] = d[7:0];
  endtask

  // One read strobe; ROM reads are acked after dly idle request cycles (dly < TO).
  task automatic rd(input logic [22:0] a, input int dly, input logic [15:0] rdat);
    logic        hit;
    logic [15:0] expd;
    hit = m_sram_en & a[20];
    bus.cart_address = a;
    bus.cart_cs      = 1'b1;
    bus.cart_oe      = 1'b1;
    tick();
    if (hit) begin
      expd = {8'hFF, m_sram[a[3:0]]};
      chk("sram_no_req", bus.mem_req, 1'b0);
      chk("sram_en_early", bus.cart_data_en, 1'b0);
      tick();
      chk("sram_en", bus.cart_data_en, 1'b1);
      chk("sram_data", bus.cart_data, expd);
      chk("sram_no_req2", bus.mem_req, 1'b0);
    end else begin
      expd = rdat;
      chk("rom_req", bus.mem_req, 1'b1);
      chk("rom_addr", bus.mem_addr, {m_bank[a[20:18]], a[17:0]});
      for (int i = 0; i < dly; i++) tick();
      chk("rom_en_before_ack", bus.cart_data_en, 1'b0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rdat;
      tick();
      bus.mem_ack = 1'b0;
      chk("rom_en", bus.cart_data_en, 1'b1);
      chk("rom_data", bus.cart_data, expd);
      chk("rom_req_drop", bus.mem_req, 1'b0);
    end
    tick();
    chk("hold_en", bus.cart_data_en, 1'b1);
    bus.cart_cs = 1'b0;
    bus.cart_oe = 1'b0;
    tick();
    chk("en_fall", bus.cart_data_en, 1'b0);
    chk("data_kept", bus.cart_data, expd);
    chk("tmo_flag", bus.timeout_err, m_tmo);
    tick();
  endtask

  initial begin
    logic [22:0] a;
    logic [15:0] d;
    logic [23:0] exp_addr;
    bus.cart_address = '0; bus.cart_cs = 0; bus.cart_oe = 0; bus.cart_lwr = 0;
    bus.cart_uwr = 0; bus.cart_time = 0; bus.cart_data_wr = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
    model_reset();

    // Reset state
    tick(); tick();
    SRES = 1'b1;
    tick();
    chk("rst_data", bus.cart_data, 16'h0000);
    chk("rst_en", bus.cart_data_en, 1'b0);
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_addr", bus.mem_addr, 24'h000000);
    chk("rst_tmo", bus.timeout_err, 1'b0);
    chk("rst_dtack", bus.ext_dtack, 1'b0);

    // Plain ROM read, then a banked read through slot 2
    rd(23'h000100, 5, 16'h4E71);
    wr(1'b1, 1'b1, 1'b0, 23'h00007A, 16'h000A);
    rd(23'h080010, 2, 16'h1357);

    // SRAM enable, fill the model window, write-protect and upper-byte writes
    wr(1'b1, 1'b1, 1'b0, 23'h000078, 16'h0001);
    for (int i = 0; i < 16; i++) wr(1'b0, 1'b1, 1'b0, win(4'(i)), 16'($urandom));
    wr(1'b0, 1'b1, 1'b0, 23'h100005, 16'h005A);
    rd(23'h100005, 0, 16'h0000);
    wr(1'b1, 1'b1, 1'b0, 23'h000078, 16'h0003);
    wr(1'b0, 1'b1, 1'b0, 23'h100005, 16'h0000);
    rd(23'h100005, 0, 16'h0000);
    wr(1'b1, 1'b1, 1'b0, 23'h000078, 16'h0001);
    wr(1'b0, 1'b0, 1'b1, 23'h100005, 16'h0011);
    rd(23'h100005, 0, 16'h0000);

    // Ack on the last allowed cycle must not time out
    rd(23'h000200, TO - 1, 16'hBEEF);

    // Bank write while a fetch is in flight leaves mem_addr alone
    a = 23'h0C0040;
    exp_addr = {m_bank[3], a[17:0]};
    bus.cart_address = a; bus.cart_cs = 1; bus.cart_oe = 1;
    tick();
    chk("inflight_addr0", bus.mem_addr, exp_addr);
    bus.cart_address = 23'h00007B; bus.cart_time = 1; bus.cart_lwr = 1;
    bus.cart_data_wr = 16'h0015;
    tick();
    bus.cart_lwr = 0; bus.cart_time = 0;
    m_bank[3] = 6'h15;
    tick();
    chk("inflight_addr1", bus.mem_addr, exp_addr);
    bus.mem_ack = 1; bus.mem_rdata = 16'h2468;
    tick();
    bus.mem_ack = 0;
    chk("inflight_data", bus.cart_data, 16'h2468);
    bus.cart_cs = 0; bus.cart_oe = 0;
    tick(); tick();
    rd(a, 1, 16'h0F0F);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0: begin
          a = 23'($urandom);
          a[6:0] = 7'h79 + 7'($urandom_range(0, 6));
          wr(1'b1, 1'b1, 1'b0, a, 16'($urandom));
        end
        1: wr(1'b0, 1'($urandom), 1'($urandom), win(4'($urandom)), 16'($urandom));
        2: begin
          a = 23'($urandom);
          if (m_sram_en) a[20] = 1'b0;
          rd(a, $urandom_range(0, TO - 1), 16'($urandom));
        end
        3: rd(win(4'($urandom)), $urandom_range(0, 8), 16'($urandom));
        default: wr(1'b1, 1'b1, 1'b0, 23'h000078, 16'($urandom_range(0, 3)));
      endcase
    end

    // Timeout: no ack for TO request cycles, then a late ack
    a = 23'($urandom);
    a[20] = 1'b0;
    bus.cart_address = a; bus.cart_cs = 1; bus.cart_oe = 1;
    tick();
    chk("tmo_req", bus.mem_req, 1'b1);
    for (int i = 0; i < TO - 1; i++) tick();
    chk("tmo_not_yet", bus.timeout_err, 1'b0);
    tick();
    m_tmo = 1'b1;
    chk("tmo_set", bus.timeout_err, 1'b1);
    chk("tmo_data", bus.cart_data, 16'hFFFF);
    chk("tmo_en", bus.cart_data_en, 1'b1);
    tick(); tick();
    bus.mem_ack = 1; bus.mem_rdata = 16'h1234;
    tick();
    bus.mem_ack = 0;
    chk("late_ack_req", bus.mem_req, 1'b0);
    chk("late_ack_data", bus.cart_data, 16'hFFFF);
    for (int i = 0; i < 4; i++) tick();
    chk("late_ack_no_refetch", bus.mem_req, 1'b0);
    bus.cart_cs = 0; bus.cart_oe = 0;
    tick();
    chk("tmo_en_fall", bus.cart_data_en, 1'b0);
    chk("tmo_sticky", bus.timeout_err, 1'b1);
    tick();
    rd(23'h000300, 3, 16'hCAFE);

    // Reset in the middle of a fetch
    wr(1'b1, 1'b1, 1'b0, 23'h00007A, 16'h0033);
    bus.cart_address = 23'h080020; bus.cart_cs = 1; bus.cart_oe = 1;
    tick();
    chk("mid_req", bus.mem_req, 1'b1);
    tick();
    SRES = 1'b0; bus.cart_cs = 0; bus.cart_oe = 0;
    tick();
    model_reset();
    chk("mid_rst_req", bus.mem_req, 1'b0);
    chk("mid_rst_tmo", bus.timeout_err, 1'b0);
    SRES = 1'b1;
    tick();
    bus.mem_ack = 1; bus.mem_rdata = 16'h5555;
    tick();
    bus.mem_ack = 0;
    tick();
    chk("stray_ack_en", bus.cart_data_en, 1'b0);
    chk("stray_ack_req", bus.mem_req, 1'b0);
    rd(23'h080020, 3, 16'h7777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/md_cart_bridge.md
Name: md_cart_bridge

Overview:
Cartridge-side responder attached to the board's cart bus (cart_address/cs/oe/lwr/uwr/time/data_wr in, cart_data/cart_data_en/ext_dtack out). Turns 68k/DMA cartridge reads into word fetches on a ROM memory request port, answers within the bus window, and implements the SSF2-style bank mapper and a battery-save SRAM, both controlled from the TIME ($A130xx) region. All cart-side strobes are active-high. cart_address is the 68k word address (A23:A1).

Parameters:
SRAM_AW, 13, SRAM byte address width (8 KB).
MAPPER_EN, 1, 1 = bank registers active; 0 = linear map, bank writes ignored.
ROM_TIMEOUT, 48, MCLK2 cycles allowed from read start to mem_ack before timeout.

Ports:
MCLK2  in  1  system clock
SRES  in  1  synchronous reset, active-low
cart_address  in  23  68k word address
cart_cs  in  1  cartridge select
cart_oe  in  1  read strobe
cart_lwr  in  1  low-byte write strobe
cart_uwr  in  1  high-byte write strobe
cart_time  in  1  TIME region select
cart_data_wr  in  16  write data
cart_data  out  16  read data to board
cart_data_en  out  1  cart_data valid, board may drive VD
ext_dtack  out  1  tied 0 (bus timing owned by the VDP)
mem_req  out  1  ROM fetch request, held until mem_ack
mem_addr  out  24  ROM word address after mapping
mem_ack  in  1  one-cycle pulse, mem_rdata valid
mem_rdata  in  16  ROM word
timeout_err  out  1  sticky: a fetch missed ROM_TIMEOUT

Behaviour:
- Reset (SRES=0 on a MCLK2 edge): state IDLE; cart_data=0, cart_data_en=0, mem_req=0, mem_addr=0, timeout_err=0, ext_dtack=0; bank[i]=i for i=0..7; sram_en=0, sram_wp=0. SRAM contents are not cleared. Reset mid-fetch drops mem_req immediately. A mem_ack arriving after the drop is ignored.
- read_go = cart_cs & cart_oe & ~cart_time & ~active_q, where active_q = registered (cart_cs & cart_oe). Evaluation is edge-based: one fetch per strobe.
- Address map: slot = cart_address[20:18]. mapped = {bank[slot][5:0], cart_address[17:0]}. bank[0] is fixed at 0. With MAPPER_EN=0, mapped = {3'b0, cart_address[20:0]}.
- sram_hit = sram_en & cart_address[20]. SRAM byte index = cart_address[SRAM_AW-1:0].
- FSM:
  - IDLE:
    - read_go & sram_hit -> SRAM_RD.
    - read_go & ~sram_hit -> FETCH. Set mem_req=1 and mem_addr=mapped. Load timeout counter.
  - SRAM_RD: 1-cycle synchronous read. Then cart_data={8'hFF, byte}, cart_data_en=1 -> HOLD. Total latency 2 cycles.
  - FETCH: hold mem_req until mem_ack.
    - On mem_ack: mem_req=0, cart_data=mem_rdata, cart_data_en=1 -> HOLD.
    - Counter reaching 0 first: timeout_err=1, cart_data=16'hFFFF, cart_data_en=1 -> ABANDON. ABANDON waits for mem_ack, then goes to HOLD (or to IDLE if the strobe has already dropped).
  - HOLD: keep cart_data/en stable while cart_cs & cart_oe. When either drops: cart_data_en=0 next cycle -> IDLE. cart_data retains its value.
- Writes (sampled on the rising edge of (cart_lwr|cart_uwr) & (cart_cs|cart_time)):
  - cart_time & cart_lwr & cart_address[6:0]==7'h78: sram_en=cart_data_wr[0], sram_wp=cart_data_wr[1].
  - cart_time & cart_lwr & cart_address[6:0] in 7'h79..7'h7F (MAPPER_EN=1): bank[address[2:0]]=cart_data_wr[5:0].
  - cart_cs & cart_lwr & sram_hit & ~sram_wp: SRAM byte = cart_data_wr[7:0].
  - cart_uwr to SRAM, and all ROM writes, are ignored.
- Writes are accepted in any FSM state. A bank write during FETCH does not alter the in-flight mem_addr.
- Simultaneous read_go and write edge: the write is applied and the read also proceeds. The read uses the pre-write bank value.
- Timeout counter is ROM_TIMEOUT-1 down to 0, sized by $clog2.

Test Plan:
- Reset, then read cart_address=23'h000100; mem_ack 5 cycles later with 16'h4E71 -> mem_addr=24'h000100, cart_data_en rises the cycle after ack, cart_data=16'h4E71, en falls one cycle after cart_oe falls.
- Time write lwr at word 7'h7A, data 6'h0A; then read cart_address=23'h080010 (slot 2) -> mem_addr=24'h280010.
- Time write 7'h78 data 1; write lwr at cart_address=23'h100005 data 8'h5A; read the same address -> cart_data=16'hFF5A after 2 cycles, no mem_req.
- Set sram_wp (write 7'h78 data 3); write 8'h00 to the same SRAM byte; read back -> 16'hFF5A unchanged.
- Withhold mem_ack for 48 cycles -> timeout_err=1, cart_data=16'hFFFF, cart_data_en=1. A late ack does not start a new fetch; timeout_err stays 1 until SRES.
- Assert SRES mid-FETCH -> mem_req=0 next edge, banks return to identity, a subsequent read fetches mem_addr=cart_address.
